// File: rtl/src_reg_sel_pkg.sv
// Shared constants and one-hot helpers for the destination-bank read sequencer.
// Helpers work on a fixed-width vector so that any NSLOT up to MAX_SLOT can share them.
package src_reg_sel_pkg;

  localparam int NSLOT_DEF = 3;
  localparam int MAX_SLOT  = 32;

  typedef logic [MAX_SLOT-1:0] slotVec_t;

  // Reset slot of both pointers: the writer starts on its top slot.
  localparam slotVec_t RST_ONEHOT = slotVec_t'(1) << (NSLOT_DEF - 1);

  function automatic slotVec_t rstOneHot(input int n);
    slotVec_t v;
    v = '0;
    v[n-1] = 1'b1;
    return v;
  endfunction

  // Rotate-left by one within an n-bit ring: bit n-1 wraps to bit 0.
  function automatic slotVec_t rotl1(input slotVec_t v, input int n);
    slotVec_t r;
    r = '0;
    for (int i = 0; i < n && i < MAX_SLOT; i++) begin
      r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

  function automatic slotVec_t rotN(input slotVec_t v, input int n, input int k);
    slotVec_t r;
    r = v;
    for (int j = 0; j < k && j < MAX_SLOT; j++) begin
      r = rotl1(r, n);
    end
    return r;
  endfunction

  function automatic logic isOneHot(input slotVec_t v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/src_reg_sel_onehot_ring.sv
// N-bit one-hot rotator with advance, parallel load and sync reset.
// An illegal (non-one-hot) value is replaced by the reset slot on the next edge.
module onehot_ring
  import src_reg_sel_pkg::*;
#(
  parameter int N = NSLOT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         ld,
  input  logic [N-1:0] ldVal,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] RST_VAL = N'(rstOneHot(N));

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (ld) begin
      q <= ldVal;
    end else if (!isOneHot(slotVec_t'(q))) begin
      q <= RST_VAL;
    end else if (adv) begin
      q <= N'(rotl1(slotVec_t'(q), N));
    end
  end

endmodule

// File: rtl/src_reg_sel.sv
// Read-side sequencer for the destination register bank: tracks occupancy from the
// writer's load strobe and walks a one-hot read select through slots in write order.
module src_reg_sel
  import src_reg_sel_pkg::*;
#(
  parameter int NSLOT = NSLOT_DEF,
  parameter int CW    = $clog2(NSLOT + 1)
) (
  input  logic             CLK1,
  input  logic             RST_C,
  input  logic             LDD,
  input  logic             RDY,
  input  logic             CLR,
  output logic [NSLOT-1:0] RSEL,
  output logic [NSLOT-1:0] WSEL,
  output logic             VALID,
  output logic             FULL,
  output logic [CW-1:0]    CNT,
  output logic             OVF,
  output logic             UDF
);

  logic [CW-1:0]    cnt;
  logic             rd;
  logic             ovfEv;
  logic             udfEv;
  logic             rAdv;
  logic [NSLOT-1:0] wNext;

  // Handshake: a read is accepted in any cycle where VALID and RDY are both high;
  // VALID depends only on registered state, never on RDY, and the consumer samples
  // bank data (selected by RSEL) during that same cycle.
  assign VALID = (cnt != '0);
  assign FULL  = (cnt == CW'(NSLOT));
  assign CNT   = cnt;

  assign rd    = VALID & RDY;
  assign udfEv = RDY & ~VALID;
  // Writing into a full bank overwrites the oldest entry, so the reader skips it.
  assign ovfEv = LDD & FULL & ~rd;
  assign rAdv  = rd | ovfEv;
  assign wNext = LDD ? NSLOT'(rotl1(slotVec_t'(WSEL), NSLOT)) : WSEL;

  onehot_ring #(.N(NSLOT)) u_wring (
    .clk   (CLK1),
    .rst   (RST_C),
    .adv   (LDD),
    .ld    (1'b0),
    .ldVal ('0),
    .q     (WSEL)
  );

  onehot_ring #(.N(NSLOT)) u_rring (
    .clk   (CLK1),
    .rst   (RST_C),
    .adv   (rAdv),
    .ld    (CLR),
    .ldVal (wNext),
    .q     (RSEL)
  );

  always_ff @(posedge CLK1) begin
    if (RST_C) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (LDD && !rd && !FULL) begin
      cnt <= cnt + CW'(1);
    end else if (rd && !LDD) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Sticky error flags survive a flush; only reset clears them.
  always_ff @(posedge CLK1) begin
    if (RST_C) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (ovfEv) OVF <= 1'b1;
      if (udfEv) UDF <= 1'b1;
    end
  end

  aRingAligned : assert property (@(posedge CLK1) disable iff (RST_C)
    !FULL |-> (rotN(slotVec_t'(RSEL), NSLOT, int'(cnt)) == slotVec_t'(WSEL)))
    else $error("read pointer not aligned with write pointer");

endmodule

// File: tb/tb_src_reg_sel.sv
// Bench for src_reg_sel: directed sequences then random traffic, checked every
// cycle against a queue-of-slot-indices model of the bank.
module tb_src_reg_sel;

  localparam int NSLOT = 3;
  localparam int CW    = $clog2(NSLOT + 1);

  logic             CLK1;
  logic             RST_C;
  logic             LDD;
  logic             RDY;
  logic             CLR;
  logic [NSLOT-1:0] RSEL;
  logic [NSLOT-1:0] WSEL;
  logic             VALID;
  logic             FULL;
  logic [CW-1:0]    CNT;
  logic             OVF;
  logic             UDF;

  src_reg_sel #(.NSLOT(NSLOT), .CW(CW)) dut (
    .CLK1  (CLK1),
    .RST_C (RST_C),
    .LDD   (LDD),
    .RDY   (RDY),
    .CLR   (CLR),
    .RSEL  (RSEL),
    .WSEL  (WSEL),
    .VALID (VALID),
    .FULL  (FULL),
    .CNT   (CNT),
    .OVF   (OVF),
    .UDF   (UDF)
  );

  // Clock / reset block
  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the bank holds the slot indices written, oldest first.
  int slotQ[$];
  int wIdx;
  logic mOvf;
  logic mUdf;
  int nChecks;
  int nFails;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NSLOT-1:0] oneHot(input int idx);
    logic [NSLOT-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic modelStep(input logic ldd, input logic rdy, input logic clr, input logic rst);
    int occ;
    logic mValid;
    logic mFull;
    logic mRd;
    if (rst) begin
      slotQ.delete();
      wIdx = NSLOT - 1;
      mOvf = 1'b0;
      mUdf = 1'b0;
    end else begin
      occ    = slotQ.size();
      mValid = (occ != 0);
      mFull  = (occ == NSLOT);
      mRd    = mValid && rdy;
      if (rdy && !mValid) mUdf = 1'b1;
      if (ldd && mFull && !mRd) mOvf = 1'b1;
      if (clr) begin
        slotQ.delete();
        if (ldd) wIdx = (wIdx + 1) % NSLOT;
      end else begin
        if (mRd) void'(slotQ.pop_front());
        if (ldd) begin
          if (slotQ.size() == NSLOT) void'(slotQ.pop_front());
          slotQ.push_back(wIdx);
          wIdx = (wIdx + 1) % NSLOT;
        end
      end
    end
  endtask

  task automatic checkAll();
    logic [NSLOT-1:0] expR;
    expR = (slotQ.size() != 0) ? oneHot(slotQ[0]) : oneHot(wIdx);
    checkVal("RSEL",  32'(RSEL),  32'(expR));
    checkVal("WSEL",  32'(WSEL),  32'(oneHot(wIdx)));
    checkVal("CNT",   32'(CNT),   32'(slotQ.size()));
    checkVal("VALID", 32'(VALID), 32'(slotQ.size() != 0));
    checkVal("FULL",  32'(FULL),  32'(slotQ.size() == NSLOT));
    checkVal("OVF",   32'(OVF),   32'(mOvf));
    checkVal("UDF",   32'(UDF),   32'(mUdf));
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic cycle(input logic ldd, input logic rdy, input logic clr, input logic rst);
    LDD   = ldd;
    RDY   = rdy;
    CLR   = clr;
    RST_C = rst;
    modelStep(ldd, rdy, clr, rst);
    @(posedge CLK1);
    #1;
    checkAll();
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    wIdx    = NSLOT - 1;
    mOvf    = 1'b0;
    mUdf    = 1'b0;
    LDD     = 1'b0;
    RDY     = 1'b0;
    CLR     = 1'b0;
    RST_C   = 1'b1;

    // Reset, then idle
    cycle(0, 0, 0, 1);
    checkVal("rst_rsel", 32'(RSEL), 32'(3'b100));
    checkVal("rst_wsel", 32'(WSEL), 32'(3'b100));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);

    // Fill three slots
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    checkVal("fill_full", 32'(FULL), 32'd1);
    checkVal("fill_rsel", 32'(RSEL), 32'(3'b100));

    // Drain three slots
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    checkVal("drain_valid", 32'(VALID), 32'd0);
    checkVal("drain_udf",   32'(UDF),   32'd0);

    // Simultaneous write and read from empty
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0);
    checkVal("wr_rd_cnt", 32'(CNT), 32'd1);
    checkVal("wr_rd_udf", 32'(UDF), 32'd1);

    // Overflow then flush
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checkVal("ovf_flag", 32'(OVF), 32'd1);
    checkVal("ovf_cnt",  32'(CNT), 32'd3);
    cycle(0, 0, 1, 0);
    checkVal("clr_cnt",  32'(CNT), 32'd0);
    checkVal("clr_ovf",  32'(OVF), 32'd1);
    checkVal("clr_align", 32'(RSEL), 32'(WSEL == RSEL ? RSEL : ~RSEL));

    // Flush with a same-cycle write, then reset mid-transfer at CNT=2
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checkVal("pre_rst_cnt", 32'(CNT), 32'd2);
    cycle(1, 1, 0, 1);
    checkVal("mid_rst_rsel", 32'(RSEL), 32'(3'b100));
    checkVal("mid_rst_cnt",  32'(CNT),  32'd0);

    // Random traffic with biased phases, occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      int ldBias;
      int rdBias;
      ldBias = ((i / 50) % 3 == 0) ? 80 : 40;
      rdBias = ((i / 50) % 3 == 1) ? 80 : 40;
      cycle(($urandom_range(0, 99) < ldBias),
            ($urandom_range(0, 99) < rdBias),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 127) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
